// File: rtl/qam16_pkg.sv
// qam16_pkg: shared FSM states, index width and PAM-4 level constants for the 16-QAM mapper/detector
package qam16_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;
    localparam int IDX_W = 2;
    function automatic int pam4_level(input logic [IDX_W-1:0] idx, input int q);
        return (2 * int'(idx) - 3) <<< q;
    endfunction
endpackage

// File: rtl/pam4_level_map.sv
// pam4_level_map: 2-bit index to signed PAM-4 level; GRAY_MAP_EN selects Gray-decoded indices
module pam4_level_map
    import qam16_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic [IDX_W-1:0]    idx,
    output logic signed [N-1:0] level
);
    logic [IDX_W-1:0] bin;
`ifdef GRAY_MAP_EN
    assign bin = {idx[1], idx[1] ^ idx[0]};
`else
    assign bin = idx;
`endif
    assign level = N'(pam4_level(bin, Q));
endmodule

// File: rtl/qam16_pair_mapper.sv
// qam16_pair_mapper: 8-bit word to four PAM-4 levels with valid/ready, frame counter and zero padding (GRAY_MAP_EN selects Gray mapping)
module qam16_pair_mapper
    import qam16_pkg::*;
#(
    parameter int N       = 16,
    parameter int Q       = 8,
    parameter int PAD_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] xI1,
    output logic signed [N-1:0] xQ1,
    output logic signed [N-1:0] xI2,
    output logic signed [N-1:0] xQ2,
    output logic                out_pad,
    output logic                out_last,
    output logic [15:0]         out_sym_cnt
);
    state_t              state, state_nxt;
    logic                can_load, accept, pad_load, last_pad, beat_last;
    logic [7:0]          pad_cnt;
    logic [15:0]         beat_cnt;
    logic signed [N-1:0] lv [4];

    for (genvar i = 0; i < 4; i++) begin : g_map
        pam4_level_map #(.N(N), .Q(Q)) u_map (.idx(in_data[2*i +: 2]), .level(lv[i]));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (state == PAD)  state_nxt = last_pad ? IDLE : PAD;
        else if (accept)   state_nxt = !in_last ? DATA : (PAD_LEN > 0 ? PAD : IDLE);
    end

    // Handshake and beat-load decode
    always_comb begin
        can_load  = !out_valid || out_ready;
        in_ready  = (state != PAD) && can_load;
        accept    = in_valid && in_ready;
        pad_load  = (state == PAD) && can_load;
        last_pad  = pad_load && (pad_cnt == 8'(PAD_LEN - 1));
        beat_last = accept ? (in_last && PAD_LEN == 0) : last_pad;
    end

    // Beat index within frame and pad position
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            beat_cnt <= '0;
            pad_cnt  <= '0;
        end else begin
            if (accept || pad_load) beat_cnt <= beat_last ? 16'd0 : beat_cnt + 16'd1;
            if (pad_load)           pad_cnt  <= last_pad ? 8'd0 : pad_cnt + 8'd1;
        end

    // Output register: load data or pad beat, hold under backpressure, drain otherwise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pad     <= 1'b0;
            out_last    <= 1'b0;
            out_sym_cnt <= '0;
            {xI1, xQ1, xI2, xQ2} <= '0;
        end else if (accept || pad_load) begin
            out_valid   <= 1'b1;
            out_pad     <= !accept;
            out_last    <= beat_last;
            out_sym_cnt <= beat_cnt;
            xI1 <= accept ? lv[0] : '0;
            xQ1 <= accept ? lv[1] : '0;
            xI2 <= accept ? lv[2] : '0;
            xQ2 <= accept ? lv[3] : '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_qam16_pair_mapper.sv
// tb_qam16_pair_mapper: directed checks of mapping, padding, backpressure and reset for qam16_pair_mapper (GRAY_MAP_EN aware)
module tb_qam16_pair_mapper;
    localparam logic [15:0] M3 = 16'hFD00, M1 = 16'hFF00, P1 = 16'h0100, P3 = 16'h0300;
`ifdef GRAY_MAP_EN
    localparam logic [7:0] W_A = 8'hB4, W_B = 8'h1E;
`else
    localparam logic [7:0] W_A = 8'hE4, W_B = 8'h1B;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic in_ready, out_valid, out_pad, out_last;
    logic signed [15:0] xI1, xQ1, xI2, xQ2;
    logic [15:0] out_sym_cnt;

    logic v0 = 1'b0, l0 = 1'b0, r0 = 1'b1;
    logic [7:0] d0 = 8'h00;
    logic rdy0, ov0, pad0, last0;
    logic signed [15:0] a0, b0, c0, e0;
    logic [15:0] cnt0;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    qam16_pair_mapper #(.N(16), .Q(8), .PAD_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .xI1(xI1), .xQ1(xQ1), .xI2(xI2), .xQ2(xQ2),
        .out_pad(out_pad), .out_last(out_last), .out_sym_cnt(out_sym_cnt)
    );

    qam16_pair_mapper #(.N(16), .Q(8), .PAD_LEN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
        .in_data(d0), .in_last(l0), .out_valid(ov0), .out_ready(r0),
        .xI1(a0), .xQ1(b0), .xI2(c0), .xQ2(e0),
        .out_pad(pad0), .out_last(last0), .out_sym_cnt(cnt0)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [15:0] i1, input logic [15:0] q1,
                              input logic [15:0] i2, input logic [15:0] q2,
                              input logic pad, input logic last, input logic [15:0] cnt);
        check({tag, ".valid"}, 16'(out_valid), 16'd1);
        check({tag, ".xI1"}, xI1, i1);
        check({tag, ".xQ1"}, xQ1, q1);
        check({tag, ".xI2"}, xI2, i2);
        check({tag, ".xQ2"}, xQ2, q2);
        check({tag, ".pad"}, 16'(out_pad), 16'(pad));
        check({tag, ".last"}, 16'(out_last), 16'(last));
        check({tag, ".cnt"}, out_sym_cnt, cnt);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic pad_run(input string tag, input bit chk_ready);
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            check_beat($sformatf("%s.pad%0d", tag, k), 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, k == 6, 16'(k));
            if (chk_ready && k < 6) check($sformatf("%s.pad_rdy%0d", tag, k), 16'(in_ready), 16'd0);
            if (k == 6) drive(1'b0, 8'h00, 1'b0);
        end
        @(negedge clk);
        check({tag, ".drained"}, 16'(out_valid), 16'd0);
    endtask

    initial begin
        @(negedge clk);
        check("rst.valid", 16'(out_valid), 16'd0);
        check("rst.cnt", out_sym_cnt, 16'd0);
        check("rst.levels", xI1 | xQ1 | xI2 | xQ2, 16'd0);
        check("rst.last_pad", {14'd0, out_last, out_pad}, 16'd0);
        check("rst.ready", 16'(in_ready), 16'd1);
        rst_n = 1'b1;

        // Frame of three words then four pad beats
        drive(1'b1, W_A, 1'b0);
        @(negedge clk);
        check_beat("f1.w0", M3, M1, P1, P3, 1'b0, 1'b0, 16'd0);
        drive(1'b1, W_B, 1'b0);
        @(negedge clk);
        check_beat("f1.w1", P3, P1, M1, M3, 1'b0, 1'b0, 16'd1);
        drive(1'b1, 8'h55, 1'b1);
        @(negedge clk);
        check_beat("f1.w2", M1, M1, M1, M1, 1'b0, 1'b0, 16'd2);
        check("f1.pad_rdy2", 16'(in_ready), 16'd0);
        drive(1'b1, 8'h00, 1'b0);
        pad_run("f1", 1'b1);

        // Backpressure: hold one beat for five cycles, then release
        out_ready = 1'b0;
        drive(1'b1, 8'h00, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h55, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check_beat($sformatf("bp.hold%0d", k), M3, M3, M3, M3, 1'b0, 1'b0, 16'd0);
            check($sformatf("bp.ready%0d", k), 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_beat("bp.w1", M1, M1, M1, M1, 1'b0, 1'b0, 16'd1);
        drive(1'b1, W_A, 1'b1);
        @(negedge clk);
        check_beat("bp.w2", M3, M1, P1, P3, 1'b0, 1'b0, 16'd2);
        drive(1'b0, 8'h00, 1'b0);
        pad_run("bp", 1'b0);

        // Reset during a pad beat
        drive(1'b1, W_B, 1'b1);
        @(negedge clk);
        check_beat("rp.w0", P3, P1, M1, M3, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_beat("rp.pad1", 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'd1);
        rst_n = 1'b0;
        #1;
        check("rp.valid", 16'(out_valid), 16'd0);
        check("rp.flags", {14'd0, out_last, out_pad}, 16'd0);
        check("rp.cnt", out_sym_cnt, 16'd0);
        check("rp.ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, W_A, 1'b0);
        @(negedge clk);
        check_beat("rp.new", M3, M1, P1, P3, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("rp.drained", 16'(out_valid), 16'd0);

        // PAD_LEN=0 instance: back-to-back single-word frames
        v0 = 1'b1; d0 = W_A; l0 = 1'b1;
        @(negedge clk);
        check("z.f1.valid", 16'(ov0), 16'd1);
        check("z.f1.last", 16'(last0), 16'd1);
        check("z.f1.cnt", cnt0, 16'd0);
        check("z.f1.xI1", a0, M3);
        check("z.f1.xQ2", e0, P3);
        check("z.f1.ready", 16'(rdy0), 16'd1);
        d0 = W_B; l0 = 1'b1;
        @(negedge clk);
        check("z.f2.last", 16'(last0), 16'd1);
        check("z.f2.cnt", cnt0, 16'd0);
        check("z.f2.xI1", a0, P3);
        check("z.f2.pad", 16'(pad0), 16'd0);
        d0 = 8'h55; l0 = 1'b0;
        @(negedge clk);
        check("z.f3.last", 16'(last0), 16'd0);
        check("z.f3.cnt", cnt0, 16'd0);
        check("z.f3.xQ1", b0, M1);
        d0 = 8'h00;
        @(negedge clk);
        check("z.f3b.cnt", cnt0, 16'd1);
        check("z.f3b.xI2", c0, M3);
        v0 = 1'b0;
        @(negedge clk);
        check("z.drained", 16'(ov0), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
